interval_timer_ctrl: RTL and testbench

Sequencing controller that turns a free-running 4-bit enable/count datapath into a programmable interval timer. The host programs a period and selects one-shot or periodic mode, then starts, holds or stops the timer. The block owns the count register and the enable/clear sequencing, and produces tick/done/err pulses for downstream logic (LED blinkers, sample strobes).

---
 rtl/interval_timer_pkg.sv | 14 +
 rtl/interval_timer_ctrl_if.sv | 29 ++
 rtl/interval_counter.sv | 26 ++
 rtl/interval_timer_ctrl.sv | 77 +++++++
 tb/tb_interval_timer_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared types and constants for the interval timer
package interval_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// rtl/interval_timer_ctrl_if.sv - host control/status bundle for the interval timer
interface interval_timer_ctrl_if
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             stop;
  logic             hold;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             err;

  modport master (
    output start, stop, hold, mode, period,
    input  busy, count, tick, done, err
  );

  modport slave (
    input  start, stop, hold, mode, period,
    output busy, count, tick, done, err
  );

endinterface

// File: rtl/interval_counter.sv
// rtl/interval_counter.sv - count register with sync clear, enable and wrap at a terminal value
module interval_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = (count == term);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - IDLE/RUN sequencer driving the interval counter and tick/done/err pulses
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic             wrap;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;

  // stop beats start in IDLE, so a simultaneous request is a no-op
  assign accept  = (state == IDLE) && bus.start && !bus.stop && (bus.period != '0);
  assign cnt_clr = accept || ((state == RUN) && bus.stop);
  assign cnt_en  = (state == RUN) && !bus.stop && !bus.hold;

  interval_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (period_q - WIDTH'(1)),
    .count (bus.count),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      bus.busy <= 1'b0;
      bus.tick <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      bus.tick <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            period_q <= bus.period;
            mode_q   <= bus.mode;
            state    <= RUN;
            bus.busy <= 1'b1;
          end else if (bus.start && !bus.stop) begin
            bus.err <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (!bus.hold && wrap) begin
            bus.tick <= 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              bus.done <= 1'b1;
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - scoreboard bench for the interval timer controller
module tb_interval_timer_ctrl;

  typedef struct packed {
    logic       busy;
    logic [3:0] count;
    logic       tick;
    logic       done;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  logic       m_run;
  logic [3:0] m_cnt;
  logic [3:0] m_pq;
  logic       m_mq;

  interval_timer_ctrl_if #(.WIDTH(4)) bus ();

  interval_timer_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Predict the next cycle from the current inputs, push it, then clock and compare.
  task automatic step(input string name);
    exp_t e;
    exp_t got;
    e = '0;
    if (!rst) begin
      m_run = 1'b0; m_cnt = 4'd0; m_pq = 4'd0; m_mq = 1'b0;
    end else if (!m_run) begin
      if (bus.start && !bus.stop) begin
        if (bus.period != 4'd0) begin
          m_pq = bus.period; m_mq = bus.mode; m_cnt = 4'd0; m_run = 1'b1;
        end else begin
          e.err = 1'b1;
        end
      end
    end else if (bus.stop) begin
      m_run = 1'b0; m_cnt = 4'd0;
    end else if (!bus.hold) begin
      if (m_cnt == m_pq - 4'd1) begin
        m_cnt = 4'd0; e.tick = 1'b1;
        if (!m_mq) begin
          e.done = 1'b1; m_run = 1'b0;
        end
      end else begin
        m_cnt = m_cnt + 4'd1;
      end
    end
    e.busy  = m_run;
    e.count = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.busy, bus.count, bus.tick, bus.done, bus.err};
    e = sb.pop_front();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s busy/count/tick/done/err got %b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
               name, got.busy, got.count, got.tick, got.done, got.err,
               e.busy, e.count, e.tick, e.done, e.err);
    end
  endtask

  task automatic kick(input logic [3:0] p, input logic md);
    bus.period = p; bus.mode = md; bus.start = 1'b1;
    step("start");
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step("reset0");
    step("reset1");
    n_tests++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b count=%0d want 0/0", bus.busy, bus.count);
    end
    rst = 1'b1;
  endtask

  task automatic test_periodic();
    logic [3:0] want_cnt [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    kick(4'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("periodic");
      n_tests++;
      if (bus.count !== want_cnt[i] || bus.tick !== (want_cnt[i] == 4'd0) ||
          bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL periodic_seq[%0d] count=%0d tick=%b done=%b busy=%b want count=%0d",
                 i, bus.count, bus.tick, bus.done, bus.busy, want_cnt[i]);
      end
    end
    bus.stop = 1'b1; step("periodic_stop"); bus.stop = 1'b0;
  endtask

  task automatic test_oneshot();
    kick(4'd3, 1'b0);
    step("oneshot1");
    step("oneshot2");
    step("oneshot_end");
    n_tests++;
    if (bus.tick !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL oneshot_done tick=%b done=%b busy=%b count=%0d want 1/1/0/0",
               bus.tick, bus.done, bus.busy, bus.count);
    end
    step("oneshot_idle1");
    step("oneshot_idle2");
  endtask

  task automatic test_hold_stop();
    kick(4'd3, 1'b1);
    step("hs_c1");
    step("hs_c2");
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("hold");
      n_tests++;
      if (bus.count !== 4'd2 || bus.tick !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_freeze[%0d] count=%0d tick=%b want 2/0", i, bus.count, bus.tick);
      end
    end
    bus.hold = 1'b0;
    step("hold_release");
    n_tests++;
    if (bus.tick !== 1'b1 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_release tick=%b count=%0d want 1/0", bus.tick, bus.count);
    end
    step("hs_c1b");
    step("hs_c2b");
    bus.stop = 1'b1;
    step("stop_at_wrap");
    bus.stop = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.tick !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_at_wrap busy=%b count=%0d tick=%b want 0/0/0", bus.busy, bus.count, bus.tick);
    end
  endtask

  task automatic test_illegal();
    kick(4'd0, 1'b1);
    n_tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse err=%b busy=%b want 1/0", bus.err, bus.busy);
    end
    step("err_clear");
    bus.stop = 1'b1;
    kick(4'd5, 1'b1);
    bus.stop = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop busy=%b err=%b want 0/0", bus.busy, bus.err);
    end
    kick(4'd3, 1'b1);
    bus.start = 1'b1; bus.period = 4'd7; bus.mode = 1'b0;
    step("restart_ign1");
    step("restart_ign2");
    step("restart_ign3");
    bus.start = 1'b0;
    n_tests++;
    if (bus.tick !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ignored tick=%b busy=%b want 1/1", bus.tick, bus.busy);
    end
    bus.stop = 1'b1; step("illegal_stop"); bus.stop = 1'b0;
  endtask

  task automatic test_period_edges();
    int n;
    kick(4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("p1");
      n_tests++;
      if (bus.tick !== 1'b1 || bus.count !== 4'd0) begin
        n_fail++;
        $display("FAIL p1_tick[%0d] tick=%b count=%0d want 1/0", i, bus.tick, bus.count);
      end
    end
    bus.stop = 1'b1; step("p1_stop"); bus.stop = 1'b0;
    kick(4'd15, 1'b0);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      step("p15");
      n++;
    end
    n_tests++;
    if (n != 15) begin
      n_fail++;
      $display("FAIL p15_done_latency cycles=%0d want 15", n);
    end
  endtask

  task automatic test_reset_mid_run();
    kick(4'd5, 1'b1);
    step("rm1"); step("rm2"); step("rm3");
    rst = 1'b0; bus.start = 1'b1; bus.period = 4'd2;
    step("rm_reset");
    n_tests++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run busy=%b count=%0d tick=%b want 0/0/0", bus.busy, bus.count, bus.tick);
    end
    step("rm_reset_start");
    rst = 1'b1; bus.start = 1'b0;
    step("rm_after");
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    bus.mode = 1'b0; bus.period = 4'd0;
    m_run = 1'b0; m_cnt = 4'd0; m_pq = 4'd0; m_mq = 1'b0;
    #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_hold_stop();
    test_illegal();
    test_period_edges();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
